// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and helpers for the decoder scan controller.
// The one-hot compare can be enabled with the DECODER_ONEHOT_CHECK_EN macro.
package decoder_scan_ctrl_pkg;

   localparam int unsigned SEL_W_DEF = 4;
   localparam int unsigned OUT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Callers truncate the result to the decoder output width.
   function automatic logic [63:0] onehot(input int unsigned code);
      return 64'd1 << code;
   endfunction

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// Dwell counter for the scan controller.
// Clear has priority over enable. tick_o marks the last hold cycle of a code.
module dwell_timer
   import decoder_scan_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned DWELL = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sequencer that walks a one-hot decoder through every select code.
// The one-hot compare and error status exist only when DECODER_ONEHOT_CHECK_EN is defined.
module decoder_scan_ctrl
   import decoder_scan_ctrl_pkg::*;
#(
   parameter int unsigned SEL_W = SEL_W_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF,
   parameter int unsigned DWELL = 20,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             done,
   input  logic [OUT_W-1:0] dec_in,
   output logic             err,
   output logic [SEL_W:0]   err_cnt,
   output logic [SEL_W-1:0] first_err_sel
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             tick;

   dwell_timer #(
      .CNT_W (CNT_W),
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk    (clk),
      .rst    (rst),
      .clr_i  ((state_q != ST_DWELL) || tick),
      .en_i   (state_q == ST_DWELL),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DWELL;
               sel_d   = '0;
            end
         end
         ST_DWELL: begin
            // Abort beats a coinciding last-hold cycle: no compare, no step.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (sel_q == SEL_W'(OUT_W - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  sel_d = sel_q + SEL_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   assign sel  = sel_q;
   assign busy = (state_q == ST_DWELL);
   assign done = (state_q == ST_DONE);

`ifdef DECODER_ONEHOT_CHECK_EN
   logic             err_q, err_d;
   logic [SEL_W:0]   err_cnt_q, err_cnt_d;
   logic [SEL_W-1:0] first_q, first_d;
   logic             mismatch;

   assign mismatch = (dec_in != OUT_W'(onehot(32'(sel_q))));

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      first_d   = first_q;
      if ((state_q == ST_IDLE) && start) begin
         err_d     = 1'b0;
         err_cnt_d = '0;
         first_d   = '0;
      end else if ((state_q == ST_DWELL) && !abort && tick && mismatch) begin
         err_d     = 1'b1;
         err_cnt_d = err_cnt_q + (SEL_W + 1)'(1);
         if (!err_q) begin
            first_d = sel_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         first_q   <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         first_q   <= first_d;
      end
   end

   assign err           = err_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_sel = first_q;
`else
   logic unused_dec_in;
   assign unused_dec_in  = ^dec_in;
   assign err            = 1'b0;
   assign err_cnt        = '0;
   assign first_err_sel  = '0;
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: one instance at DWELL=20, one at DWELL=1.
// Expected error results follow DECODER_ONEHOT_CHECK_EN the same way the design does.
module tb_decoder_scan_ctrl;

   localparam int DW = 20;

   logic        clk = 1'b0;
   logic        rst, start_a, abort_a, start_b, abort_b;
   logic [3:0]  sel_a, sel_b, first_a, first_b;
   logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
   logic [4:0]  cnt_a, cnt_b;
   logic [15:0] dec_a, dec_b;

   logic [15:0] fault_on;
   logic [15:0] fault_pat [16];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Decoder model: exact one-hot, corrupted for the codes marked in fault_on.
   always_comb begin
      dec_a = (16'd1 << sel_a) ^ (fault_on[sel_a] ? fault_pat[sel_a] : 16'd0);
   end
   assign dec_b = 16'd1 << sel_b;

   decoder_scan_ctrl #(.SEL_W(4), .OUT_W(16), .DWELL(DW), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .sel(sel_a),
      .busy(busy_a), .done(done_a), .dec_in(dec_a), .err(err_a),
      .err_cnt(cnt_a), .first_err_sel(first_a)
   );

   decoder_scan_ctrl #(.SEL_W(4), .OUT_W(16), .DWELL(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .sel(sel_b),
      .busy(busy_b), .done(done_b), .dec_in(dec_b), .err(err_b),
      .err_cnt(cnt_b), .first_err_sel(first_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Number of faulty codes among those compared before code 'upto'.
   function automatic int model_cnt(input int upto);
      int n = 0;
      for (int c = 0; c < upto; c++) if (fault_on[c]) n++;
`ifndef DECODER_ONEHOT_CHECK_EN
      n = 0;
`endif
      return n;
   endfunction

   function automatic int model_first(input int upto);
      int f = 0;
      for (int c = upto - 1; c >= 0; c--) if (fault_on[c]) f = c;
`ifndef DECODER_ONEHOT_CHECK_EN
      f = 0;
`endif
      return f;
   endfunction

   task automatic chk_status_a(input string tag, input int upto);
      chk({tag, "_err"},   err_a,   (model_cnt(upto) != 0) ? 1 : 0);
      chk({tag, "_cnt"},   cnt_a,   model_cnt(upto));
      chk({tag, "_first"}, first_a, model_first(upto));
   endtask

   // One scan on the DWELL=20 instance; abort_k/rst_k/ign_k < 0 disables that event.
   task automatic scan_a(input int abort_k, input int rst_k, input int ign_k, input bit with_abort);
      start_a = 1'b1;
      abort_a = with_abort;
      step();
      start_a = 1'b0;
      abort_a = 1'b0;
      chk("first_busy", busy_a, 1);
      chk("start_err_clr", err_a, 0);
      chk("start_cnt_clr", cnt_a, 0);
      for (int k = 0; k <= 16 * DW; k++) begin
         if (k == 16 * DW) begin
            chk("done_at_latency", done_a, 1);
            chk("busy_at_done", busy_a, 0);
            chk_status_a("done", 16);
         end else begin
            chk("sel_hold", sel_a, k / DW);
            chk("busy_scan", busy_a, 1);
            chk("no_early_done", done_a, 0);
         end
         if (k == ign_k) start_a = 1'b1;
         if (k == abort_k) begin
            abort_a = 1'b1;
            step();
            abort_a = 1'b0;
            start_a = 1'b0;
            chk("abort_busy", busy_a, 0);
            chk("abort_done", done_a, 0);
            chk("abort_sel", sel_a, k / DW);
            chk_status_a("abort", k / DW);
            for (int j = 0; j < 4; j++) begin
               step();
               chk("abort_idle_done", done_a, 0);
               chk("abort_idle_sel", sel_a, k / DW);
            end
            return;
         end
         if (k == rst_k) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            start_a = 1'b0;
            chk("midrst_sel", sel_a, 0);
            chk("midrst_busy", busy_a, 0);
            chk("midrst_done", done_a, 0);
            chk("midrst_cnt", cnt_a, 0);
            chk("midrst_err", err_a, 0);
            for (int j = 0; j < 4; j++) begin
               step();
               chk("midrst_idle_done", done_a, 0);
               chk("midrst_idle_busy", busy_a, 0);
            end
            return;
         end
         step();
         start_a = 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
         chk("post_done", done_a, 0);
         chk("post_sel", sel_a, 15);
         chk_status_a("post", 16);
         step();
      end
   endtask

   task automatic randomize_faults();
      fault_on = 16'($urandom);
      for (int c = 0; c < 16; c++) fault_pat[c] = 16'($urandom_range(1, 65535));
   endtask

   initial begin
      rst = 1'b1; start_a = 1'b1; abort_a = 1'b0; start_b = 1'b1; abort_b = 1'b0;
      fault_on = '0;
      for (int c = 0; c < 16; c++) fault_pat[c] = '0;
      repeat (3) step();
      chk("rst_sel", sel_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_first", first_a, 0);
      chk("rst_b_busy", busy_b, 0);
      chk("rst_b_sel", sel_b, 0);
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (3) step();
      chk("idle_after_rst", busy_a, 0);
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      step();
      chk("abort_in_idle", busy_a, 0);
      chk("abort_in_idle_sel", sel_a, 0);

      // Nominal scan with an ignored start while sel=3.
      scan_a(-1, -1, $urandom_range(3 * DW, 4 * DW - 1), 1'b0);

      // Directed fault at code 5: bit 5 dropped, bit 12 raised.
      fault_on = 16'd1 << 5;
      fault_pat[5] = (16'd1 << 5) | (16'd1 << 12);
      scan_a(-1, -1, -1, 1'b0);

      for (int r = 0; r < 3; r++) begin
         randomize_faults();
         scan_a(-1, -1, -1, 1'b0);
      end

      // Abort while sel=7, avoiding that code's compare cycle.
      randomize_faults();
      scan_a($urandom_range(7 * DW, 8 * DW - 2), -1, -1, 1'b0);

      // Restart after abort, with abort asserted alongside start in IDLE.
      scan_a(-1, -1, -1, 1'b1);

      // Reset while sel=9.
      randomize_faults();
      scan_a(-1, $urandom_range(9 * DW, 10 * DW - 1), -1, 1'b0);

      // DWELL=1 instance: one code per cycle.
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         if (k == 16) begin
            chk("b_done_at_16", done_b, 1);
            chk("b_busy_at_done", busy_b, 0);
            chk("b_err", err_b, 0);
            chk("b_cnt", cnt_b, 0);
         end else begin
            chk("b_sel", sel_b, k);
            chk("b_busy", busy_b, 1);
            chk("b_no_early_done", done_b, 0);
         end
         step();
      end
      chk("b_sel_hold", sel_b, 15);
      chk("b_done_pulse", done_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
